// File: rtl/sensor_frame_scheduler_if.sv
// Handshake bundle between the per-sensor sampling logic, the frame scheduler and the SPI TX.
// The master modport is the scheduler side; the slave modport is the requester/SPI side.
interface sensor_frame_scheduler_if #(
    parameter int unsigned SENSORS  = 4,
    parameter int unsigned BITWIDTH = 32
);
    logic [SENSORS-1:0]            req;
    logic [SENSORS*2*BITWIDTH-1:0] sample;
    logic [SENSORS-1:0]            grant;
    logic                          tx_valid;
    logic [15:0]                   tx_data;
    logic                          tx_ready;
    logic                          busy;

    modport master (
        input  req, sample, tx_ready,
        output grant, tx_valid, tx_data, busy
    );

    modport slave (
        output req, sample, tx_ready,
        input  grant, tx_valid, tx_data, busy
    );
endinterface

// File: rtl/sensor_frame_scheduler.sv
// Round-robin scheduler framing one sensor sample as SYNC, header, W data words (LS first).
// Define SENSOR_FRAME_CHECKSUM_EN to append a 16-bit checksum word (header + data words).
module sensor_frame_scheduler #(
    parameter int unsigned SENSORS   = 4,
    parameter int unsigned BITWIDTH  = 32,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic                     clk,
    input  logic                     rst,
    sensor_frame_scheduler_if.master bus
);
    localparam int unsigned SW    = 2 * BITWIDTH;
    localparam int unsigned W     = SW / 16;
    localparam int unsigned PTR_W = (SENSORS > 1) ? $clog2(SENSORS) : 1;
    localparam int unsigned IDX_W = $clog2(W + 1);
    localparam logic [IDX_W-1:0] W_LAST  = IDX_W'(W);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(SENSORS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR,
        ST_DATA
`ifdef SENSOR_FRAME_CHECKSUM_EN
        , ST_CSUM
`endif
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [7:0]         r_seq;
    logic [IDX_W-1:0]   r_idx;
    logic [SW-1:0]      r_buf;
    logic [15:0]        r_tx_data;
    logic               r_tx_valid;
    logic [SENSORS-1:0] r_grant;

    state_t             w_state_nx;
    logic [PTR_W-1:0]   w_ptr_nx;
    logic [7:0]         w_seq_nx;
    logic [IDX_W-1:0]   w_idx_nx;
    logic [SW-1:0]      w_buf_nx;
    logic [15:0]        w_tx_data_nx;
    logic               w_tx_valid_nx;
    logic [SENSORS-1:0] w_grant_nx;

    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_cand;
    logic               w_xfer;
    logic [15:0]        w_header;
    logic               w_last_data;

`ifdef SENSOR_FRAME_CHECKSUM_EN
    logic [15:0]        r_csum;
    logic [15:0]        w_csum_nx;
`endif

    assign w_xfer      = r_tx_valid && bus.tx_ready;
    assign w_header    = {r_seq, 8'(r_ptr)};
    assign w_last_data = (r_idx == W_LAST);

    assign bus.grant    = r_grant;
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = (r_state != ST_IDLE);

    // Winner search starts one past the last served sensor and wraps, so sensor 0 wins after reset.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int unsigned i = 0; i < SENSORS; i++) begin
            w_cand = (w_cand == PTR_MAX) ? '0 : w_cand + 1'b1;
            if (!w_found && bus.req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_state_nx = ST_SYNC;
            ST_SYNC: if (w_xfer)  w_state_nx = ST_HDR;
            ST_HDR:  if (w_xfer)  w_state_nx = ST_DATA;
            ST_DATA: begin
                if (w_xfer && w_last_data) begin
`ifdef SENSOR_FRAME_CHECKSUM_EN
                    w_state_nx = ST_CSUM;
`else
                    w_state_nx = ST_IDLE;
`endif
                end
            end
`ifdef SENSOR_FRAME_CHECKSUM_EN
            ST_CSUM: if (w_xfer) w_state_nx = ST_IDLE;
`endif
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Output/datapath logic: the word loaded on each transfer edge is the next word of the frame
    always_comb begin
        w_ptr_nx      = r_ptr;
        w_seq_nx      = r_seq;
        w_idx_nx      = r_idx;
        w_buf_nx      = r_buf;
        w_tx_data_nx  = r_tx_data;
        w_tx_valid_nx = r_tx_valid;
        w_grant_nx    = '0;
`ifdef SENSOR_FRAME_CHECKSUM_EN
        w_csum_nx     = r_csum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_buf_nx             = bus.sample[int'(w_winner)*SW +: SW];
                    w_grant_nx[w_winner] = 1'b1;
                    w_ptr_nx             = w_winner;
                    w_tx_data_nx         = SYNC_WORD;
                    w_tx_valid_nx        = 1'b1;
                end
            end
            ST_SYNC: begin
                if (w_xfer) begin
                    w_tx_data_nx = w_header;
`ifdef SENSOR_FRAME_CHECKSUM_EN
                    w_csum_nx    = w_header;
`endif
                end
            end
            ST_HDR: begin
                if (w_xfer) begin
                    w_tx_data_nx = r_buf[15:0];
                    w_buf_nx     = r_buf >> 16;
                    w_idx_nx     = IDX_W'(1);
`ifdef SENSOR_FRAME_CHECKSUM_EN
                    w_csum_nx    = r_csum + r_buf[15:0];
`endif
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    if (w_last_data) begin
`ifdef SENSOR_FRAME_CHECKSUM_EN
                        w_tx_data_nx  = r_csum;
`else
                        w_tx_valid_nx = 1'b0;
                        w_seq_nx      = r_seq + 8'd1;
`endif
                    end else begin
                        w_tx_data_nx = r_buf[15:0];
                        w_buf_nx     = r_buf >> 16;
                        w_idx_nx     = r_idx + 1'b1;
`ifdef SENSOR_FRAME_CHECKSUM_EN
                        w_csum_nx    = r_csum + r_buf[15:0];
`endif
                    end
                end
            end
`ifdef SENSOR_FRAME_CHECKSUM_EN
            ST_CSUM: begin
                if (w_xfer) begin
                    w_tx_valid_nx = 1'b0;
                    w_seq_nx      = r_seq + 8'd1;
                end
            end
`endif
            default: begin
                w_tx_valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr      <= PTR_MAX;
            r_seq      <= '0;
            r_idx      <= '0;
            r_buf      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_grant    <= '0;
`ifdef SENSOR_FRAME_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_ptr      <= w_ptr_nx;
            r_seq      <= w_seq_nx;
            r_idx      <= w_idx_nx;
            r_buf      <= w_buf_nx;
            r_tx_data  <= w_tx_data_nx;
            r_tx_valid <= w_tx_valid_nx;
            r_grant    <= w_grant_nx;
`ifdef SENSOR_FRAME_CHECKSUM_EN
            r_csum     <= w_csum_nx;
`endif
        end
    end
endmodule

// File: tb/tb_sensor_frame_scheduler.sv
// Scoreboard bench for sensor_frame_scheduler: a frame-level model queues expected words and
// grants when requests are issued; a negedge monitor pops and compares them as the DUT emits.
module tb_sensor_frame_scheduler;
    localparam int N  = 2;
    localparam int BW = 32;
    localparam int SW = 2 * BW;
    localparam int W  = SW / 16;
    localparam logic [15:0] SYNC = 16'hA55A;
    localparam logic [SW-1:0] FIXED = 64'h0004_0003_0002_0001;

    typedef struct {
        logic [15:0] w;
        bit          last;
    } exp_word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sensor_frame_scheduler_if #(.SENSORS(N), .BITWIDTH(BW)) bus ();

    sensor_frame_scheduler #(
        .SENSORS(N), .BITWIDTH(BW), .SYNC_WORD(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    exp_word_t     wq[$];
    int            gq[$];
    int            errors = 0;
    int            checks = 0;
    int            m_last = N - 1;
    int            m_seq  = 0;
    logic [SW-1:0] smp[N];
    bit            ready_rand = 1'b0;
    int            bp_left = 0;
    bit            rst_arm = 1'b0;
    bit            prev_hold = 1'b0;
    bit            expect_idle = 1'b0;
    logic [15:0]   prev_data = '0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected frame of sensor k carrying sample s, with the model's current sequence number.
    task automatic push_frame(input int k, input logic [SW-1:0] s);
        logic [15:0] hdr;
        logic [15:0] word;
`ifdef SENSOR_FRAME_CHECKSUM_EN
        logic [15:0] sum;
`endif
        hdr = {8'(m_seq), 8'(k)};
        wq.push_back(exp_word_t'{SYNC, 1'b0});
        wq.push_back(exp_word_t'{hdr, 1'b0});
`ifdef SENSOR_FRAME_CHECKSUM_EN
        sum = hdr;
`endif
        for (int j = 0; j < W; j++) begin
            word = s[j*16 +: 16];
`ifdef SENSOR_FRAME_CHECKSUM_EN
            sum = sum + word;
            wq.push_back(exp_word_t'{word, 1'b0});
`else
            wq.push_back(exp_word_t'{word, j == W - 1});
`endif
        end
`ifdef SENSOR_FRAME_CHECKSUM_EN
        wq.push_back(exp_word_t'{sum, 1'b1});
`endif
        gq.push_back(k);
        m_seq  = (m_seq + 1) % 256;
        m_last = k;
    endtask

    task automatic drive_sample();
        for (int i = 0; i < N; i++) bus.sample[i*SW +: SW] = smp[i];
    endtask

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (bus.grant[i] && bus.req[i]) begin
                bus.req[i] = 1'b0;
                smp[i] = {$urandom, $urandom};
            end
        end
        drive_sample();
        bus.tx_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (bp_left > 0 && bus.tx_valid && bus.tx_data == 16'h0002) begin
            bus.tx_ready = 1'b0;
            bp_left--;
        end
        if (rst_arm && bus.tx_valid && bus.tx_data == 16'h0003) begin
            rst_arm = 1'b0;
            rst = 1'b0;
            #1;
            check(bus.grant == '0,     "midrst_grant",    32'(bus.grant),    32'h0);
            check(bus.tx_valid == 1'b0, "midrst_tx_valid", 32'(bus.tx_valid), 32'h0);
            check(bus.tx_data == 16'h0, "midrst_tx_data",  32'(bus.tx_data),  32'h0);
            check(bus.busy == 1'b0,    "midrst_busy",     32'(bus.busy),     32'h0);
            wq.delete();
            gq.delete();
            m_last = N - 1;
            m_seq  = 0;
            bus.req = '0;
        end
    endtask

    // Raise the requests in s together; the model serves them round-robin from its last winner.
    task automatic episode(input logic [N-1:0] s, input bit fixed);
        bit pend[N];
        int cyc;
        for (int i = 0; i < N; i++) begin
            pend[i] = s[i];
            if (s[i]) smp[i] = fixed ? FIXED : {$urandom, $urandom};
        end
        for (int n = 0; n < N; n++) begin
            for (int d = 1; d <= N; d++) begin
                int c;
                c = (m_last + d) % N;
                if (pend[c]) begin
                    push_frame(c, smp[c]);
                    pend[c] = 1'b0;
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        drive_sample();
        bus.req = s;
        cyc = 0;
        while (rst && !(bus.req == '0 && wq.size() == 0 && gq.size() == 0)) begin
            drive_cycle();
            cyc++;
            if (cyc > 300) begin
                checks++;
                errors++;
                $display("FAIL episode_timeout: got %0d words pending, expected 0", wq.size());
                wq.delete();
                gq.delete();
                bus.req = '0;
                break;
            end
        end
    endtask

    // Monitor: compares grants, transferred words, holding under backpressure, idle gap and busy.
    always @(negedge clk) begin
        if (!rst) begin
            prev_hold   = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (bus.grant != '0) begin
                check(gq.size() != 0, "grant_unexpected", 32'(bus.grant), 32'h0);
                if (gq.size() != 0) begin
                    int k;
                    k = gq.pop_front();
                    check(bus.grant == N'(1 << k), "grant", 32'(bus.grant), 32'(1 << k));
                end
            end
            if (prev_hold)
                check(bus.tx_valid && bus.tx_data == prev_data, "hold", 32'(bus.tx_data), 32'(prev_data));
            if (expect_idle) begin
                check(bus.tx_valid == 1'b0, "idle_gap", 32'(bus.tx_valid), 32'h0);
                expect_idle = 1'b0;
            end
            check(bus.busy == bus.tx_valid, "busy", 32'(bus.busy), 32'(bus.tx_valid));
            if (bus.tx_valid && bus.tx_ready) begin
                check(wq.size() != 0, "word_unexpected", 32'(bus.tx_data), 32'h0);
                if (wq.size() != 0) begin
                    exp_word_t e;
                    e = wq.pop_front();
                    check(bus.tx_data == e.w, "word", 32'(bus.tx_data), 32'(e.w));
                    expect_idle = e.last;
                end
            end
            prev_hold = bus.tx_valid && !bus.tx_ready;
            prev_data = bus.tx_data;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req      = '0;
        bus.sample   = '0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < N; i++) smp[i] = '0;

        // Reset held with random inputs
        repeat (6) begin
            @(posedge clk);
            #1;
            bus.req      = N'($urandom);
            bus.sample   = {$urandom, $urandom, $urandom, $urandom};
            bus.tx_ready = 1'($urandom);
            @(negedge clk);
            check(bus.grant == '0,      "rst_grant",    32'(bus.grant),    32'h0);
            check(bus.tx_valid == 1'b0, "rst_tx_valid", 32'(bus.tx_valid), 32'h0);
            check(bus.tx_data == 16'h0, "rst_tx_data",  32'(bus.tx_data),  32'h0);
            check(bus.busy == 1'b0,     "rst_busy",     32'(bus.busy),     32'h0);
        end
        @(posedge clk);
        #1;
        bus.req      = '0;
        bus.tx_ready = 1'b1;
        rst          = 1'b1;

        // Single frame, then the same frame with three stalled cycles on word 0002
        episode(2'b01, 1'b1);
        bp_left = 3;
        episode(2'b01, 1'b1);
        bp_left = 0;

        // Contention with steady and random backpressure
        repeat (3) episode(2'b11, 1'b0);
        ready_rand = 1'b1;
        repeat (30) episode(N'($urandom_range(1, 3)), 1'b0);

        // Reset while word 0003 is presented, then both sensors request
        ready_rand = 1'b0;
        rst_arm = 1'b1;
        episode(2'b01, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        episode(2'b11, 1'b0);

        // Enough sensor-0 frames for the sequence number to wrap past 255
        ready_rand = 1'b1;
        repeat (257) episode(2'b01, 1'b0);

        repeat (4) drive_cycle();
        check(wq.size() == 0, "leftover_words", 32'(wq.size()), 32'h0);
        check(gq.size() == 0, "leftover_grants", 32'(gq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sensor_frame_scheduler.md
# sensor_frame_scheduler

Round-robin scheduler that shares the single SPI transmit path among `SENSORS` sample sources. It captures one requester's `2*BITWIDTH`-bit sample and serializes it as a framed sequence of 16-bit words: sync, header, data, and an optional checksum. It sits between the per-sensor sampling logic and the SPI transmitter, and replaces ad-hoc direct word feeding.

## Interface
- `SENSORS`, 4 — number of requesters, 1..256.
- `BITWIDTH`, 32 — bits per sample half; `2*BITWIDTH` must be a multiple of 16. W = `2*BITWIDTH/16` data words.
- `SYNC_WORD`, 16'hA55A — first word of every frame.

- `clk` in 1 — clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-low.
- `req` in `SENSORS` — requester i has a sample pending.
- `sample` in `SENSORS*2*BITWIDTH` — sensor i's sample at `[i*2*BITWIDTH +: 2*BITWIDTH]`.
- `grant` out `SENSORS` — one-hot, 1-cycle pulse when sensor i's sample is captured.
- `tx_valid` out 1 — `tx_data` holds a word for the SPI TX.
- `tx_data` out 16 — current word.
- `tx_ready` in 1 — SPI TX accepts a word; transfer occurs on `tx_valid && tx_ready`.
- `busy` out 1 — high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, SYNC, HDR, DATA, CSUM (CSUM exists only with the macro).
- **IDLE:** if any `req` bit is set, select winner k by searching from `ptr+1` upward, wrapping.
  - On that edge: latch `sample[k]` into the internal buffer, set `grant[k]`=1, set `ptr`=k.
  - Also on that edge: `tx_data`=`SYNC_WORD`, `tx_valid`=1, go to SYNC.
- **Word advance:** on each transfer, load the next word on the same edge; `tx_valid` stays 1, so back-to-back transfers are allowed.
  - SYNC → HDR: header = {seq[7:0], k[7:0]}.
  - HDR → DATA: data words are sent least-significant 16 bits first, W words.
  - After the last DATA word: go to CSUM (with macro) or IDLE.
- **Frame end:** on transfer of the final word, `tx_valid`←0 and state←IDLE. `seq` increments on that edge, 8-bit, wrapping 255→0.
- **Holding:** without a transfer, `tx_data` and `tx_valid` hold. `req` changes and `sample` changes after capture have no effect mid-frame.
- **Requesters:** must hold `req` until `grant`, and should drop it the cycle after `grant`. A `req` still high in IDLE is served as a new sample.
- **Widths:** word index counter is `$clog2(W+1)` bits.

## Timing
- Reset values: `grant`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `ptr`=`SENSORS`-1 (sensor 0 wins first), `seq`=0, state=IDLE.
- Latency: `req` sampled high at edge n → `grant`, `tx_valid`, and SYNC word are visible after edge n (same cycle). Combinational `req`→`grant` is forbidden.
- Frame length with `tx_ready` held high: 2+W cycles, or 3+W with checksum.
- At least one cycle with `tx_valid`=0 (IDLE) separates frames.
- Simultaneous requests: exactly one grant per frame. The others wait; no request is lost while held.
- Reset mid-frame: the asynchronous assert immediately forces every output to its reset value and abandons the frame. The frame is not resumed.
- `tx_ready` high while `tx_valid`=0 is ignored.

## Configuration
- Macro `SENSOR_FRAME_CHECKSUM_EN`.
- **Defined:** a CSUM word follows the data. It is the sum mod 2^16 of the header word and all W data words; SYNC is excluded.
- **Undefined:** no CSUM state or word; the frame ends after the last data word; the checksum adder is not built.

## Test plan
All scenarios use `SENSORS`=2, `BITWIDTH`=32, W=4.
1. **Reset:** hold `rst`=0 with random inputs → `grant`=00, `tx_valid`=0, `tx_data`=0000, `busy`=0.
2. **Single frame:** `req`=01, `sample0`=64'h0004_0003_0002_0001, `tx_ready`=1 → `grant`=01 for one cycle; words A55A, 0000, 0001, 0002, 0003, 0004, plus 000A with the macro; then `tx_valid`=0.
3. **Contention:** `req`=11 held continuously → frames alternate between sensor 0 and sensor 1.
   - Headers run 0000, 0101, 0200, 0301, …
   - Each `grant` is one-hot, and the frames are separated by one idle cycle.
4. **Backpressure:** drop `tx_ready` for 3 cycles while the word 0002 is presented → 0002 holds stable with `tx_valid`=1; the full sequence is received with no drop or duplicate.
5. **Sequence wrap:** run 256 frames from sensor 0 → the 257th header is 0000.
6. **Reset mid-frame:** assert `rst` while the word 0003 is presented, then release and raise `req`=11 → next frame is sensor 0, header 0000.
